// File: rtl/zz_quant_pkg.sv
// zz_quant_pkg: zigzag order, per-diagonal shift rules and 9-bit saturation limits shared by quantizer and dequantizer
package zz_quant_pkg;

    typedef enum logic {Q0 = 1'b0, Q1 = 1'b1} quant_sel_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} zz_state_t;

    localparam logic signed [16:0] SAT_MAX = 17'sd255;
    localparam logic signed [16:0] SAT_MIN = -17'sd256;

    // Zigzag index -> raster position {row[2:0], col[2:0]}
    localparam logic [5:0] ZZ_TBL [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [2:0] shift_q0(input logic [3:0] d);
        return d == 4'd0 ? 3'd3 : d == 4'd1 ? 3'd2 : d <= 4'd3 ? 3'd3 :
               d <= 4'd5 ? 3'd4 : d <= 4'd7 ? 3'd5 : 3'd6;
    endfunction

    function automatic logic [2:0] shift_q1(input logic [3:0] d);
        return d == 4'd0 ? 3'd3 : d <= 4'd3 ? 3'd1 : d <= 4'd5 ? 3'd2 :
               d <= 4'd7 ? 3'd3 : d <= 4'd10 ? 3'd4 : 3'd5;
    endfunction

    function automatic logic [2:0] shift_of(input quant_sel_t q, input logic [3:0] d);
        return q == Q1 ? shift_q1(d) : shift_q0(d);
    endfunction

endpackage

// File: rtl/zigzag_quantizer_if.sv
// zigzag_quantizer_if: coefficient RAM read port plus valid/ready quantized output stream
interface zigzag_quantizer_if;

    logic               read_en;
    logic [7:0]         read_addr;
    logic signed [15:0] read_data;
    logic [8:0]         out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;

    modport master (
        output read_en, read_addr, out_data, out_valid, out_last,
        input  read_data, out_ready
    );

    modport slave (
        input  read_en, read_addr, out_data, out_valid, out_last,
        output read_data, out_ready
    );

endinterface

// File: rtl/zz_out_fifo.sv
// zz_out_fifo: synchronous FIFO of {last, data} with occupancy count; head reads as zero while empty
module zz_out_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en_i,
    input  logic [W-1:0]             wr_data_i,
    input  logic                     rd_en_i,
    output logic [W-1:0]             rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    // Storage needs no reset; occupancy decides what is visible
    always_ff @(posedge clock) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Pointers and occupancy, flushed by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_en_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q <= rd_en_i ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_q  <= count_q + (AW+1)'(wr_en_i) - (AW+1)'(rd_en_i);
        end
    end

    assign rd_data_o = count_q != '0 ? mem_q[rd_ptr_q] : '0;
    assign count_o   = count_q;

endmodule

// File: rtl/zigzag_quantizer.sv
// zigzag_quantizer: reads an 8x8 coefficient block in zigzag order, shift-quantizes and saturates to 9 bits (optional QUANT_SAT_CNT_EN adds sat_count)
module zigzag_quantizer
    import zz_quant_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] ADDR_BASE  = 8'd0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               quant_sel,
    output logic               busy,
    output logic               done,
    zigzag_quantizer_if.master bus
`ifdef QUANT_SAT_CNT_EN
    ,
    output logic [6:0]         sat_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    zz_state_t          state_q, state_d;
    quant_sel_t         qsel_q, qsel_d;
    logic [5:0]         rd_idx_q, rd_idx_d;
    logic               inflight_q;
    logic [2:0]         pend_sh_q;
    logic               pend_last_q;

    logic [CW-1:0]      fifo_count;
    logic [9:0]         fifo_head;
    logic               issue, xfer, accept_start;
    logic [5:0]         rc;
    logic [3:0]         diag;

    logic signed [16:0] coef, bias, biased, shifted;
    logic               clamp_hi, clamp_lo;
    logic [8:0]         qval;

    // A read may only be launched if its result is guaranteed a FIFO slot
    assign issue        = state_q == RUN && int'(fifo_count) + int'(inflight_q) < FIFO_DEPTH;
    assign xfer         = bus.out_valid && bus.out_ready;
    assign done         = state_q == DRAIN && xfer && bus.out_last;
    assign accept_start = start && (state_q == IDLE || done);
    assign busy         = state_q != IDLE;

    assign rc            = ZZ_TBL[rd_idx_q];
    assign diag          = {1'b0, rc[5:3]} + {1'b0, rc[2:0]};
    assign bus.read_en   = issue;
    assign bus.read_addr = ADDR_BASE + {2'b00, rc};

    // Next-state: sequencing of a block and back-to-back restart on done
    always_comb begin
        state_d  = accept_start ? RUN :
                   state_q == RUN && issue && rd_idx_q == 6'd63 ? DRAIN :
                   done ? IDLE : state_q;
        rd_idx_d = issue ? rd_idx_q + 6'd1 : rd_idx_q;
        qsel_d   = accept_start ? quant_sel_t'(quant_sel) : qsel_q;
    end

    // Control registers; the shift and last tag travel with each read
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            qsel_q      <= Q0;
            rd_idx_q    <= '0;
            inflight_q  <= 1'b0;
            pend_sh_q   <= '0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            qsel_q      <= qsel_d;
            rd_idx_q    <= rd_idx_d;
            inflight_q  <= issue;
            pend_sh_q   <= shift_of(qsel_q, diag);
            pend_last_q <= rd_idx_q == 6'd63;
        end
    end

    // Round toward zero: bias negatives by 2^s-1 before the arithmetic shift
    assign coef     = {bus.read_data[15], bus.read_data};
    assign bias     = coef[16] ? (17'sd1 <<< pend_sh_q) - 17'sd1 : 17'sd0;
    assign biased   = coef + bias;
    assign shifted  = biased >>> pend_sh_q;
    assign clamp_hi = shifted > SAT_MAX;
    assign clamp_lo = shifted < SAT_MIN;
    assign qval     = clamp_hi ? SAT_MAX[8:0] : clamp_lo ? SAT_MIN[8:0] : shifted[8:0];

    zz_out_fifo #(.DEPTH(FIFO_DEPTH), .W(10)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (inflight_q),
        .wr_data_i ({pend_last_q, qval}),
        .rd_en_i   (xfer),
        .rd_data_o (fifo_head),
        .count_o   (fifo_count)
    );

    assign bus.out_valid = fifo_count != '0;
    assign bus.out_data  = fifo_head[8:0];
    assign bus.out_last  = fifo_head[9];

`ifdef QUANT_SAT_CNT_EN
    logic [6:0] sat_cnt_q, sat_cnt_d;
    logic       sat_inc;

    assign sat_inc = inflight_q && (clamp_hi || clamp_lo);

    // Per-block clamp tally, cleared when a new block is accepted
    always_comb begin
        sat_cnt_d = accept_start ? 7'd0 : sat_inc ? sat_cnt_q + 7'd1 : sat_cnt_q;
    end

    // Clamp tally register
    always_ff @(posedge clock) begin
        if (reset) sat_cnt_q <= '0;
        else       sat_cnt_q <= sat_cnt_d;
    end

    assign sat_count = sat_cnt_q;
`endif

endmodule

// File: doc/zigzag_quantizer.md
Name: zigzag_quantizer

Overview:
- Encoder-side counterpart of the Milestone 3 dequantizer.
- Reads one 8x8 block of 16-bit signed DCT coefficients from embedded RAM in zigzag order.
- Divides each coefficient by the Q0/Q1 power-of-two step for its diagonal, saturates it to 9-bit signed, and streams the 64 results out over a valid/ready interface for downstream lossless coding.

Parameters:
- FIFO_DEPTH, 4, output buffer entries (power of two, >= 3 so the stream runs at full rate).
- ADDR_BASE, 8'd0, added to the block-local address {2'b00,row,col} to form read_addr.

Ports:
- clock  in  1  system clock; everything sampled on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a block; ignored while busy.
- quant_sel  in  1  0 selects Q0, 1 selects Q1; latched on the accepted start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse in the cycle the 64th output is accepted.
- read_en  out  1  RAM read strobe.
- read_addr  out  8  ADDR_BASE + {2'b00,row,col}.
- read_data  in  16  signed coefficient, valid exactly 1 cycle after read_en.
- out_data  out  9  signed quantized coefficient.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the output.
- out_last  out  1  high with the 64th element of the block.

Behaviour:
- Reset: busy=0, done=0, read_en=0, read_addr=ADDR_BASE, out_valid=0, out_last=0, out_data=0. FIFO is flushed, counters are cleared, FSM goes to IDLE.
- Reset mid-block aborts the block. No done pulse. Buffered data is discarded.
- FSM states and transitions:
  - IDLE -> RUN on start.
  - RUN issues reads for index 0..63, then goes to DRAIN.
  - DRAIN waits until the 64th output is accepted, pulses done, then returns to IDLE.
  - start is accepted in the cycle that done pulses; busy stays high when this happens.
- Read issue: a 6-bit rd_idx is mapped to (row,col) through the zigzag table (0,0),(0,1),(1,0),(2,0),(1,1),(0,2)...(7,7). A read is issued only while (fifo_count + inflight) < FIFO_DEPTH. rd_idx increments on each issue.
- Pipeline: issue in cycle N. Data arrives in N+1. The quantized value is written into the FIFO at the end of N+1 and is visible at out_valid in N+2. With out_ready held high, first out_valid comes 3 cycles after start and throughput is 1 per cycle.
- Shift per diagonal d=row+col, carried alongside the read:
  - Q0: d=0 -> 3; d=1 -> 2; d=2..3 -> 3; d=4..5 -> 4; d=6..7 -> 5; d>=8 -> 6.
  - Q1: d=0 -> 3; d=1..3 -> 1; d=4..5 -> 2; d=6..7 -> 3; d=8..10 -> 4; d>=11 -> 5.
- Arithmetic: divide rounding toward zero. If the value is negative, add (2^s - 1), then arithmetic-shift right by s (use 17-bit intermediate). Saturate to [-256, +255].
- Handshake: a transfer occurs when out_valid && out_ready. While stalled, out_data and out_last hold stable. out_valid never drops without a transfer, except on reset.
- out_last is tagged on the entry from rd_idx 63.

Optional Feature:
- QUANT_SAT_CNT_EN defined: adds output sat_count[6:0]. It clears on the accepted start and increments once for each coefficient clamped in that block. It holds after done and resets to 0.
- QUANT_SAT_CNT_EN undefined: no port and no logic.

Decomposition:
- Package zz_quant_pkg holds:
  - quant_sel_t.
  - the zigzag index->(row,col) constant table.
  - the Q0/Q1 shift functions of d.
  - the 9-bit saturation limits.
- The dequantizer shares the same package so both use identical tables.
- Sub-module zz_out_fifo: parameterized synchronous FIFO carrying {last, data[8:0]}, with count output.

Test Plan:
- Q0 order and value: RAM[k] = k*8 (signed), start, out_ready=1 -> read_addr sequence 0,1,8,16,9,2,3,10... Each out_data = RAM[addr] >>> shift(d) (e.g. addr 0 -> 0; addr 1 -> 8>>>2 = 2). out_last and done appear on the 64th transfer, 66 cycles after start.
- Rounding and sign: (0,1)=-5 under Q0 -> -1. (0,0)=-7 -> 0. (0,0)=800 -> 100. Under Q1, (0,1)=-5 -> -2.
- Saturation: (7,7)=32767 under Q0 -> 255. (7,7)=-32768 -> -256. With QUANT_SAT_CNT_EN defined, sat_count=2.
- Backpressure: out_ready low for 10 cycles after the first out_valid -> out_data is held. read_en stops once fifo_count + inflight = 4. Resuming gives no loss or duplication; 64 unique transfers in order.
- Back-to-back blocks: start asserted with done, quant_sel flipped to Q1 -> the second block uses the Q1 shifts and busy never drops.
- Reset at element 30 -> outputs return to reset values next cycle with no done pulse. A new start produces a full, correct 64-element block.
